// File: rtl/imem_responder_if.sv
// Fetch/load bus between the host + core side and the instruction-memory responder.
// The slave modport is the responder; the master modport is the host loader and fetch unit.
interface imem_responder_if;
  logic        i_load_mode;
  logic [7:0]  i_load_byte;
  logic        i_load_valid;
  logic        o_load_ready;
  logic [15:0] o_load_words;
  logic [31:0] i_pc;
  logic        i_fetch_en;
  logic [31:0] o_instr;
  logic        o_instr_valid;
  logic        o_fault;

  modport master (
    output i_load_mode, i_load_byte, i_load_valid, i_pc, i_fetch_en,
    input  o_load_ready, o_load_words, o_instr, o_instr_valid, o_fault
  );

  modport slave (
    input  i_load_mode, i_load_byte, i_load_valid, i_pc, i_fetch_en,
    output o_load_ready, o_load_words, o_instr, o_instr_valid, o_fault
  );
endinterface

// File: rtl/imem_responder.sv
// Instruction memory with a byte-stream host load port and a one-cycle fetch port.
// Define IMEM_BOUNDS_CHECK_EN to fault fetches beyond DEPTH_WORDS instead of wrapping.
module imem_responder #(
  parameter int          DEPTH_WORDS = 256,
  parameter logic [31:0] NOP_INSTR   = 32'h00000013
) (
  input logic              clk,
  input logic              i_reset,
  imem_responder_if.slave  bus
);

  localparam int AW = $clog2(DEPTH_WORDS);

  typedef enum logic [1:0] {IDLE, LOAD, RUN} state_t;

  state_t        state;
  logic [1:0]    byte_idx;
  logic [AW-1:0] wr_ptr;
  logic [23:0]   word_buf;
  logic [15:0]   load_words;
  logic          load_ready;
  logic [31:0]   instr;
  logic          instr_valid;
  logic          fault;

  logic [31:0]   mem [DEPTH_WORDS];

  logic [AW-1:0] rd_idx;
  logic          misaligned;
  logic          out_of_range;
  logic          bad_fetch;
  logic          byte_accept;
  logic          mem_we;

  assign rd_idx     = bus.i_pc[AW+1:2];
  assign misaligned = |bus.i_pc[1:0];

`ifdef IMEM_BOUNDS_CHECK_EN
  assign out_of_range = |bus.i_pc[31:AW+2];
`else
  logic unused_pc_hi;
  assign unused_pc_hi = ^bus.i_pc[31:AW+2];
  assign out_of_range = 1'b0;
`endif

  assign bad_fetch = misaligned | out_of_range;

  // A mode change in the same cycle as a byte wins: the byte is not taken.
  assign byte_accept = (state == LOAD) && bus.i_load_mode && bus.i_load_valid;
  assign mem_we      = i_reset && byte_accept && (byte_idx == 2'd3);

  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem[wr_ptr] <= {bus.i_load_byte, word_buf};
    end
  end

  always_ff @(posedge clk) begin
    if (!i_reset) begin
      state       <= IDLE;
      byte_idx    <= 2'd0;
      wr_ptr      <= '0;
      word_buf    <= 24'd0;
      load_words  <= 16'd0;
      load_ready  <= 1'b0;
      instr       <= NOP_INSTR;
      instr_valid <= 1'b0;
      fault       <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          instr       <= NOP_INSTR;
          instr_valid <= 1'b0;
          if (bus.i_load_mode) begin
            state      <= LOAD;
            load_ready <= 1'b1;
            byte_idx   <= 2'd0;
            wr_ptr     <= '0;
            load_words <= 16'd0;
            fault      <= 1'b0;
          end else begin
            state <= RUN;
          end
        end

        LOAD: begin
          if (!bus.i_load_mode) begin
            state      <= IDLE;
            load_ready <= 1'b0;
            byte_idx   <= 2'd0;
          end else if (byte_accept) begin
            case (byte_idx)
              2'd0: word_buf[7:0]   <= bus.i_load_byte;
              2'd1: word_buf[15:8]  <= bus.i_load_byte;
              2'd2: word_buf[23:16] <= bus.i_load_byte;
              default: begin
                wr_ptr <= wr_ptr + 1'b1;
                if (load_words != 16'hFFFF) begin
                  load_words <= load_words + 16'd1;
                end
              end
            endcase
            byte_idx <= byte_idx + 2'd1;
          end
        end

        RUN: begin
          // Leaving RUN drops whatever fetch result was pending.
          if (bus.i_load_mode) begin
            state       <= IDLE;
            instr       <= NOP_INSTR;
            instr_valid <= 1'b0;
          end else if (bus.i_fetch_en) begin
            instr_valid <= 1'b1;
            if (bad_fetch) begin
              instr <= NOP_INSTR;
              fault <= 1'b1;
            end else begin
              instr <= mem[rd_idx];
            end
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

  assign bus.o_load_ready  = load_ready;
  assign bus.o_load_words  = load_words;
  assign bus.o_instr       = instr;
  assign bus.o_instr_valid = instr_valid;
  assign bus.o_fault       = fault;

endmodule
